// File: rtl/uart_tx_mmio.sv
// ---------------------------------------------------------------------------
// uart_tx_mmio
// Memory-mapped UART transmitter for a small CPU. A store to UART_BASE pushes
// one byte into a 4-deep transmit FIFO. A load from UART_BASE+4 returns STATUS,
// and a store to UART_BASE+4 clears the sticky overflow flag. A two-process FSM
// pops bytes and sends 8N1 frames on tx, LSB first.
//
// Ports
//   clk          system clock, all state changes on the rising edge
//   Reset        synchronous active-high reset
//   MemWrite     CPU store strobe
//   DataAddress  CPU data address
//   WriteData    CPU store data, bits [7:0] carry the TX byte
//   io_sel       high when DataAddress hits TXDATA or STATUS
//   io_rdata     STATUS when DataAddress is UART_BASE+4, else zero
//   tx           registered serial output, idle high
// ---------------------------------------------------------------------------
module uart_tx_mmio #(
    parameter int          CLKS_PER_BIT = 16,
    parameter logic [31:0] UART_BASE    = 32'h0000_0100
) (
    input  logic        clk,
    input  logic        Reset,
    input  logic        MemWrite,
    input  logic [31:0] DataAddress,
    input  logic [31:0] WriteData,
    output logic        io_sel,
    output logic [31:0] io_rdata,
    output logic        tx
);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} txState_t;

    localparam logic [31:0] STAT_ADDR = UART_BASE + 32'd4;
    localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);

    txState_t    r_state;
    logic [7:0]  r_fifo [4];
    logic [2:0]  r_count;
    logic [1:0]  r_rdPtr;
    logic [1:0]  r_wrPtr;
    logic        r_ovf;
    logic [15:0] r_baud;
    logic [2:0]  r_bitIdx;
    logic [7:0]  r_shift;
    logic        r_tx;

    txState_t    w_nextState;
    logic [15:0] w_baudNext;
    logic [2:0]  w_bitNext;
    logic [7:0]  w_shiftNext;
    logic        w_txNext;
    logic        w_txSel;
    logic        w_statSel;
    logic        w_push;
    logic        w_full;
    logic        w_empty;
    logic        w_pushOk;
    logic        w_overflow;
    logic        w_pop;
    logic        w_baudDone;
    logic [31:0] w_status;
    logic        w_unusedBits;

    // Address decode and FIFO handshakes. A full FIFO drops the byte even
    // when the FSM pops on the same edge, because fullness is judged on the
    // pre-edge count.
    assign w_txSel      = (DataAddress == UART_BASE);
    assign w_statSel    = (DataAddress == STAT_ADDR);
    assign w_push       = MemWrite && w_txSel;
    assign w_full       = (r_count == 3'd4);
    assign w_empty      = (r_count == 3'd0);
    assign w_pushOk     = w_push && !w_full;
    assign w_overflow   = w_push && w_full;
    assign w_pop        = (r_state == IDLE) && !w_empty;
    assign w_baudDone   = (r_baud == BAUD_LAST);
    assign w_unusedBits = ^WriteData[31:8];

    assign w_status = {28'd0, r_ovf, (r_state != IDLE), w_empty, w_full};
    assign io_sel   = w_txSel || w_statSel;
    assign io_rdata = w_statSel ? w_status : 32'h0;
    assign tx       = r_tx;

    // FIFO storage. The storage has no reset because a zero count already
    // makes any stale contents unreachable.
    always_ff @(posedge clk) begin
        if (!Reset && w_pushOk) begin
            r_fifo[r_wrPtr] <= WriteData[7:0];
        end
    end

    // FIFO pointers, occupancy and the sticky overflow flag. When an overflow
    // and a STATUS write would both affect the flag on one edge, the set takes
    // priority over the clear.
    always_ff @(posedge clk) begin
        if (Reset) begin
            r_count <= 3'd0;
            r_rdPtr <= 2'd0;
            r_wrPtr <= 2'd0;
            r_ovf   <= 1'b0;
        end else begin
            if (w_pushOk) begin
                r_wrPtr <= r_wrPtr + 2'd1;
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + 2'd1;
            end
            case ({w_pushOk, w_pop})
                2'b10:   r_count <= r_count + 3'd1;
                2'b01:   r_count <= r_count - 3'd1;
                default: r_count <= r_count;
            endcase
            if (w_overflow) begin
                r_ovf <= 1'b1;
            end else if (MemWrite && w_statSel) begin
                r_ovf <= 1'b0;
            end
        end
    end

    // Transmit state register. tx is loaded with the level for the state
    // being entered, so the line changes on the same edge as the state.
    always_ff @(posedge clk) begin
        if (Reset) begin
            r_state  <= IDLE;
            r_baud   <= 16'd0;
            r_bitIdx <= 3'd0;
            r_shift  <= 8'd0;
            r_tx     <= 1'b1;
        end else begin
            r_state  <= w_nextState;
            r_baud   <= w_baudNext;
            r_bitIdx <= w_bitNext;
            r_shift  <= w_shiftNext;
            r_tx     <= w_txNext;
        end
    end

    // Next-state logic. Each bit lasts CLKS_PER_BIT cycles of the baud
    // counter. After a data bit ends, the next line level is shift[1] because
    // the register shifts right on that same edge.
    always_comb begin
        w_nextState = r_state;
        w_baudNext  = r_baud;
        w_bitNext   = r_bitIdx;
        w_shiftNext = r_shift;
        w_txNext    = r_tx;
        case (r_state)
            IDLE: begin
                w_txNext = 1'b1;
                if (w_pop) begin
                    w_nextState = START;
                    w_baudNext  = 16'd0;
                    w_shiftNext = r_fifo[r_rdPtr];
                    w_txNext    = 1'b0;
                end
            end
            START: begin
                if (w_baudDone) begin
                    w_nextState = DATA;
                    w_baudNext  = 16'd0;
                    w_bitNext   = 3'd0;
                    w_txNext    = r_shift[0];
                end else begin
                    w_baudNext = r_baud + 16'd1;
                end
            end
            DATA: begin
                if (w_baudDone) begin
                    w_baudNext  = 16'd0;
                    w_shiftNext = {1'b0, r_shift[7:1]};
                    if (r_bitIdx == 3'd7) begin
                        w_nextState = STOP;
                        w_txNext    = 1'b1;
                    end else begin
                        w_bitNext = r_bitIdx + 3'd1;
                        w_txNext  = r_shift[1];
                    end
                end else begin
                    w_baudNext = r_baud + 16'd1;
                end
            end
            STOP: begin
                if (w_baudDone) begin
                    w_nextState = IDLE;
                    w_baudNext  = 16'd0;
                    w_txNext    = 1'b1;
                end else begin
                    w_baudNext = r_baud + 16'd1;
                end
            end
            default: begin
                w_nextState = IDLE;
                w_txNext    = 1'b1;
            end
        endcase
    end

endmodule
